// File: rtl/md_unit_pkg.sv
// Shared types for the M-extension multiply/divide unit: opcodes, funct3 selectors, FSM states.
package md_unit_pkg;

    typedef enum logic [6:0] {
        OP_IMM = 7'b0010011,
        OP_R   = 7'b0110011
    } opcode_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_unit_decoder.sv
// Combinational decode of opcode/funct3/funct7 into M-extension select and operation attributes.
module md_unit_decoder
    import md_unit_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic       md_sel_c,
    output logic       is_div_c,
    output logic       is_signed_a_c,
    output logic       is_signed_b_c,
    output logic       want_high_c,
    output logic       want_rem_c
);

    always_comb begin
        md_sel_c      = (opcode_i == OP_R) && (funct7_i == FUNCT7_MULDIV);
        is_div_c      = 1'b0;
        is_signed_a_c = 1'b0;
        is_signed_b_c = 1'b0;
        want_high_c   = 1'b0;
        want_rem_c    = 1'b0;
        case (md_op_e'(funct3_i))
            MD_MULH:   begin want_high_c = 1'b1; is_signed_a_c = 1'b1; is_signed_b_c = 1'b1; end
            MD_MULHSU: begin want_high_c = 1'b1; is_signed_a_c = 1'b1; end
            MD_MULHU:  want_high_c = 1'b1;
            MD_DIV:    begin is_div_c = 1'b1; is_signed_a_c = 1'b1; is_signed_b_c = 1'b1; end
            MD_DIVU:   is_div_c = 1'b1;
            MD_REM:    begin is_div_c = 1'b1; want_rem_c = 1'b1; is_signed_a_c = 1'b1; is_signed_b_c = 1'b1; end
            MD_REMU:   begin is_div_c = 1'b1; want_rem_c = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multicycle RV32M/RV64M multiply/divide unit: iterative shift-add multiply and restoring divide.
// Define MD_FAST_MUL_EN to complete all multiplies in one cycle with a full-width multiplier.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            md_sel_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    logic is_div, is_signed_a, is_signed_b, want_high, want_rem;

    md_unit_decoder u_dec (
        .opcode_i      (opcode_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .md_sel_c      (md_sel_o),
        .is_div_c      (is_div),
        .is_signed_a_c (is_signed_a),
        .is_signed_b_c (is_signed_b),
        .want_high_c   (want_high),
        .want_rem_c    (want_rem)
    );

    md_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] prod_q, prod_nxt;
    logic [XLEN-1:0]   opnd_q, res_q;
    logic              is_div_q, want_high_q, want_rem_q, neg_res_q, neg_rem_q;

    // Operand magnitudes taken at accept
    logic            a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_abs, b_abs;
    assign a_neg    = is_signed_a & rs1_i[XLEN-1];
    assign b_neg    = is_signed_b & rs2_i[XLEN-1];
    assign a_abs    = a_neg ? -rs1_i : rs1_i;
    assign b_abs    = b_neg ? -rs2_i : rs2_i;
    assign div_zero = (rs2_i == '0);
    assign div_ovf  = is_signed_a && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

    // One iteration: prod_q holds {acc, multiplier} for multiply or {remainder, quotient} for divide
    logic [XLEN:0] mul_sum, div_sh, div_diff;
    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    assign div_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};

    always_comb begin
        prod_nxt = {1'b0, prod_q[2*XLEN-1:1]};
        if (is_div_q) begin
            if (!div_diff[XLEN]) prod_nxt = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
            else                 prod_nxt = {div_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end else if (prod_q[0]) begin
            prod_nxt = {mul_sum, prod_q[XLEN-1:1]};
        end
    end

    // Sign correction applied on the final iteration
    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   fix_res;
    always_comb begin
        mul_full = neg_res_q ? -prod_nxt : prod_nxt;
        if (is_div_q) begin
            if (want_rem_q) fix_res = neg_rem_q ? -prod_nxt[2*XLEN-1:XLEN] : prod_nxt[2*XLEN-1:XLEN];
            else            fix_res = neg_res_q ? -prod_nxt[XLEN-1:0] : prod_nxt[XLEN-1:0];
        end else begin
            fix_res = want_high_q ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
        end
    end

`ifdef MD_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
    assign fast_a = {{XLEN{a_neg}}, rs1_i};
    assign fast_b = {{XLEN{b_neg}}, rs2_i};
    assign fast_p = fast_a * fast_b;
`endif

    // Requests that finish straight from IDLE
    logic            spec_hit;
    logic [XLEN-1:0] spec_res;
    always_comb begin
        spec_hit = 1'b0;
        spec_res = '0;
        if (is_div) begin
            if (div_zero) begin
                spec_hit = 1'b1;
                spec_res = want_rem ? rs1_i : '1;
            end else if (div_ovf) begin
                spec_hit = 1'b1;
                spec_res = want_rem ? '0 : rs1_i;
            end
        end
`ifdef MD_FAST_MUL_EN
        else begin
            spec_hit = 1'b1;
            spec_res = want_high ? fast_p[2*XLEN-1:XLEN] : fast_p[XLEN-1:0];
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            prod_q      <= '0;
            opnd_q      <= '0;
            res_q       <= '0;
            is_div_q    <= 1'b0;
            want_high_q <= 1'b0;
            want_rem_q  <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            result_o    <= '0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state_q <= MD_IDLE;
                cnt_q   <= '0;
                busy_o  <= 1'b0;
            end else begin
                case (state_q)
                    MD_IDLE: begin
                        if (start_i && md_sel_o) begin
                            is_div_q    <= is_div;
                            want_high_q <= want_high;
                            want_rem_q  <= want_rem;
                            neg_res_q   <= a_neg ^ b_neg;
                            neg_rem_q   <= a_neg;
                            opnd_q      <= is_div ? b_abs : a_abs;
                            prod_q      <= {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
                            cnt_q       <= '0;
                            busy_o      <= 1'b1;
                            res_q       <= spec_res;
                            state_q     <= spec_hit ? MD_DONE : MD_CALC;
                        end
                    end
                    MD_CALC: begin
                        prod_q <= prod_nxt;
                        if (cnt_q == CNT_W'(XLEN - 1)) begin
                            cnt_q   <= '0;
                            res_q   <= fix_res;
                            state_q <= MD_DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    MD_DONE: begin
                        state_q  <= MD_IDLE;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        result_o <= res_q;
                    end
                    default: state_q <= MD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: scoreboard of expected results/latencies, flush, reset and decode checks.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int unsigned XLEN = 32;
`ifdef MD_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    typedef struct {
        string           tag;
        logic [XLEN-1:0] res;
        int              lat;
    } exp_t;

    exp_t sb_q[$];

    logic            clk_i = 1'b0;
    logic            rst_ni, start_i, flush_i;
    logic [6:0]      opcode_i, funct7_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i, rs2_i;
    logic            md_sel_o, busy_o, done_o;
    logic [XLEN-1:0] result_o;

    int n_checks = 0;
    int n_errors = 0;

    md_unit #(.XLEN(XLEN)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .opcode_i (opcode_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .md_sel_o (md_sel_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input md_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        opcode_i = OP_R;
        funct7_i = FUNCT7_MULDIV;
        funct3_i = op;
        rs1_i    = a;
        rs2_i    = b;
        start_i  = 1'b1;
    endtask

    // Issue one request, then wait (bounded) for done_o and score it
    task automatic do_op(input string tag, input md_op_e op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] res, input int lat);
        exp_t e;
        int   cyc;
        bit   busy_ok;
        e.tag = tag;
        e.res = res;
        e.lat = lat;
        @(negedge clk_i);
        drive_req(op, a, b);
        sb_q.push_back(e);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        busy_ok = (busy_o === 1'b1);
        cyc = 0;
        while (done_o !== 1'b1 && cyc < 200) begin
            @(posedge clk_i); #1;
            cyc++;
            if (done_o !== 1'b1 && busy_o !== 1'b1) busy_ok = 1'b0;
        end
        e = sb_q.pop_front();
        check({e.tag, "_done_seen"}, 64'(done_o), 64'(1));
        check({e.tag, "_result"}, 64'(result_o), 64'(e.res));
        check({e.tag, "_latency"}, 64'(cyc), 64'(e.lat));
        check({e.tag, "_busy"}, 64'(busy_ok), 64'(1));
        @(posedge clk_i); #1;
        check({e.tag, "_pulse"}, 64'(done_o), 64'(0));
        check({e.tag, "_hold"}, 64'(result_o), 64'(e.res));
    endtask

    initial begin
        bit seen;
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        flush_i  = 1'b0;
        opcode_i = '0;
        funct3_i = '0;
        funct7_i = '0;
        rs1_i    = '0;
        rs2_i    = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_result", 64'(result_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        do_op("mul",       MD_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        do_op("mul_shift", MD_MUL,    32'h12345678,  32'h00000010, 32'h23456780, MUL_LAT);
        do_op("mulh",      MD_MULH,   32'h80000000,  32'h80000000, 32'h40000000, MUL_LAT);
        do_op("mulhsu",    MD_MULHSU, 32'h80000000,  32'h80000000, 32'hC0000000, MUL_LAT);
        do_op("mulhu",     MD_MULHU,  32'h80000000,  32'h80000000, 32'h40000000, MUL_LAT);
        do_op("mulhu_max", MD_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        do_op("div_zero",  MD_DIV,    32'd7,         32'd0,        32'hFFFFFFFF, SPC_LAT);
        do_op("divu_zero", MD_DIVU,   32'd7,         32'd0,        32'hFFFFFFFF, SPC_LAT);
        do_op("remu_zero", MD_REMU,   32'd7,         32'd0,        32'd7,        SPC_LAT);
        do_op("div_ovf",   MD_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, SPC_LAT);
        do_op("rem_ovf",   MD_REM,    32'h80000000,  32'hFFFFFFFF, 32'h00000000, SPC_LAT);
        do_op("div_neg",   MD_DIV,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, DIV_LAT);
        do_op("rem_neg",   MD_REM,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, DIV_LAT);
        do_op("divu_big",  MD_DIVU,   32'hFFFFFFFF,  32'd2,        32'h7FFFFFFF, DIV_LAT);
        do_op("div_negb",  MD_DIV,    32'd100,       32'hFFFFFFF9, 32'hFFFFFFF2, DIV_LAT);
        do_op("rem_negb",  MD_REM,    32'd100,       32'hFFFFFFF9, 32'd2,        DIV_LAT);
        do_op("remu",      MD_REMU,   32'd100,       32'd7,        32'd2,        DIV_LAT);

        // Flush a DIV at cycle 10; result_o keeps the previous value (2)
        @(negedge clk_i);
        drive_req(MD_DIV, 32'hFFFFFF9C, 32'd7);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'(0));
        check("flush_done", 64'(done_o), 64'(0));
        check("flush_result", 64'(result_o), 64'(2));
        @(posedge clk_i); #1;
        do_op("mul_after_flush", MD_MUL, 32'd6, 32'd7, 32'd42, MUL_LAT);

        // Reset at cycle 5 of a MUL
        @(negedge clk_i);
        drive_req(MD_MUL, 32'd3, 32'd5);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        check("midrst_busy", 64'(busy_o), 64'(0));
        check("midrst_done", 64'(done_o), 64'(0));
        check("midrst_result", 64'(result_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) seen = 1'b1;
        end
        check("midrst_no_done", 64'(seen), 64'(0));

        // Decode: only OP_R with funct7=0000001 selects the unit
        @(negedge clk_i);
        opcode_i = OP_R;
        funct7_i = FUNCT7_MULDIV;
        #1;
        check("sel_muldiv", 64'(md_sel_o), 64'(1));
        opcode_i = OP_IMM;
        #1;
        check("sel_opimm", 64'(md_sel_o), 64'(0));
        opcode_i = OP_R;
        funct7_i = 7'b0000000;
        funct3_i = MD_MUL;
        rs1_i    = 32'd3;
        rs2_i    = 32'd5;
        start_i  = 1'b1;
        #1;
        check("sel_funct7_0", 64'(md_sel_o), 64'(0));
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("illegal_busy", 64'(busy_o), 64'(0));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) seen = 1'b1;
        end
        check("illegal_no_done", 64'(seen), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
